// File: rtl/multi_tick_generator_if.sv
// Config/enable/restart bus into the tick generator and per-channel tick/busy back out.
// The master drives configuration and channel controls; the slave (generator) drives tick and busy.
interface multi_tick_generator_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 26
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_period;
  logic              cfg_oneshot;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] ch_restart;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] busy;

  modport master (
    output cfg_we, cfg_ch, cfg_period, cfg_oneshot, ch_en, ch_restart,
    input  tick, busy
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_period, cfg_oneshot, ch_en, ch_restart,
    output tick, busy
  );
endinterface

// File: rtl/multi_tick_generator.sv
// Shared free-running prescaler feeding NUM_CH programmable periodic/one-shot tick channels.
// tick rises on the edge where a channel's count wraps; no backpressure, ticks are one-cycle pulses.
module multi_tick_generator #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 26,
  parameter int PRESCALE       = 1,
  parameter int DEFAULT_PERIOD = 50000000
) (
  input logic                   clk,
  input logic                   rst,
  multi_tick_generator_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(DEFAULT_PERIOD);

  logic pre_stb;

  if (PRESCALE > 1) begin : g_pre
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    assign pre_stb = (pre_q == PRE_W'(PRESCALE - 1));

    always_comb begin
      pre_d = pre_q + 1'b1;
      if (pre_stb) begin
        pre_d = '0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pre_q <= '0;
      end else begin
        pre_q <= pre_d;
      end
    end
  end else begin : g_nopre
    assign pre_stb = 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             oneshot_q;
    logic             oneshot_d;
    logic             tick_q;
    logic             tick_d;
    logic             busy_q;
    logic             busy_d;
    logic             cfg_hit;
    logic             active;
    logic             at_term;

    // Out-of-range cfg_ch values match no channel, so such writes fall away.
    assign cfg_hit = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
    assign active  = bus.ch_en[i] && (!oneshot_q || busy_q);
    assign at_term = (period_q != '0) && (count_q == period_q - 1'b1);

    always_comb begin
      period_d  = period_q;
      oneshot_d = oneshot_q;
      count_d   = count_q;
      busy_d    = busy_q;
      tick_d    = 1'b0;
      if (cfg_hit) begin
        period_d  = bus.cfg_period;
        oneshot_d = bus.cfg_oneshot;
        count_d   = '0;
        busy_d    = 1'b0;
      end else if (bus.ch_restart[i]) begin
        count_d = '0;
        if (oneshot_q) begin
          busy_d = 1'b1;
        end
      end else if (active && pre_stb) begin
        if (period_q == '0) begin
          // A zero period parks the channel: no ticks, any pending one-shot is abandoned.
          count_d = '0;
          busy_d  = 1'b0;
        end else if (at_term) begin
          count_d = '0;
          tick_d  = 1'b1;
          if (oneshot_q) begin
            busy_d = 1'b0;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        period_q  <= DEF_PERIOD;
        oneshot_q <= 1'b0;
        count_q   <= '0;
        tick_q    <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        period_q  <= period_d;
        oneshot_q <= oneshot_d;
        count_q   <= count_d;
        tick_q    <= tick_d;
        busy_q    <= busy_d;
      end
    end

    assign bus.tick[i] = tick_q;
    assign bus.busy[i] = busy_q;
  end
endmodule
